// File: rtl/cic_comp_pkg.sv
// Shared definitions for the CIC-compensation FIR decimator.
// Holds the control FSM state type, default parameter values and the
// width helper functions used to size ports and the accumulator.
package cic_comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    MAC,
    OUT
  } state_t;

  localparam int DEF_DW    = 35;
  localparam int DEF_CW    = 31;
  localparam int DEF_NTAP  = 15;
  localparam int DEF_DEC   = 2;
  localparam int DEF_SHIFT = 30;

  // Ceiling log2: number of bits needed to index n items.
  function automatic int clog2(input int n);
    int unsigned r;
    r = 0;
    while ((1 << r) < n) r++;
    return int'(r);
  endfunction

  // Accumulator width that cannot overflow over nh folded products.
  function automatic int acc_width(input int dw, input int cw, input int nh);
    return dw + 1 + cw + clog2(nh);
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Folded-FIR datapath: pre-adder, signed multiplier and accumulator.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clr       - zero the accumulator (takes priority over en)
//   en        - add the current product into the accumulator
//   single    - centre tap: use x0 alone instead of x0+x1
//   x0, x1    - the two symmetric samples (signed, DW bits)
//   coef      - coefficient (signed, CW bits)
//   acc       - accumulator (signed, ACCW bits)
module cic_comp_mac #(
  parameter int DW   = 35,
  parameter int CW   = 31,
  parameter int ACCW = 70
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic            single,
  input  logic [DW-1:0]   x0,
  input  logic [DW-1:0]   x1,
  input  logic [CW-1:0]   coef,
  output logic [ACCW-1:0] acc
);

  localparam int PW = DW + 1 + CW;

  logic signed [DW:0]   pre;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] pre_ext;
  logic signed [PW-1:0] coef_ext;

  always_comb begin
    if (single) pre = $signed({x0[DW-1], x0});
    else        pre = $signed({x0[DW-1], x0}) + $signed({x1[DW-1], x1});
    pre_ext  = $signed({{CW{pre[DW]}}, pre});
    coef_ext = $signed({{(DW+1){coef[CW-1]}}, coef});
    prod     = pre_ext * coef_ext;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      acc <= '0;
    else if (clr) acc <= '0;
    else if (en)  acc <= acc + {{(ACCW-PW){prod[PW-1]}}, prod};
  end

endmodule

// File: rtl/cic_comp_fir_dec.sv
// CIC-compensation FIR decimator: symmetric odd-length FIR with a
// programmable half coefficient set, decimation by DEC, one shared
// pre-add/multiply/accumulate datapath, round-half-up output with
// saturation, raw-sample bypass and overrun detection.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   clk_vld_in, dat_in       - input sample strobe and sample
//   coef_we/addr/wdata       - coefficient write (ignored while busy)
//   bypass                   - emit decimated raw samples
//   ovr_clr                  - clear sticky overrun
//   clk_vld_out, dat_out     - output strobe and held output sample
//   busy                     - operation in progress
//   sat, overrun             - sticky saturation / dropped-trigger flags
module cic_comp_fir_dec
  import cic_comp_pkg::*;
#(
  parameter int DW    = DEF_DW,
  parameter int CW    = DEF_CW,
  parameter int NTAP  = DEF_NTAP,
  parameter int DEC   = DEF_DEC,
  parameter int SHIFT = DEF_SHIFT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clk_vld_in,
  input  logic [DW-1:0]                dat_in,
  input  logic                         coef_we,
  input  logic [clog2((NTAP+1)/2)-1:0] coef_addr,
  input  logic [CW-1:0]                coef_wdata,
  input  logic                         bypass,
  input  logic                         ovr_clr,
  output logic                         clk_vld_out,
  output logic [DW-1:0]                dat_out,
  output logic                         busy,
  output logic                         sat,
  output logic                         overrun
);

  localparam int NH   = (NTAP + 1) / 2;
  localparam int KW   = clog2(NH);
  localparam int IW   = clog2(NTAP);
  localparam int PW   = clog2(DEC);
  localparam int ACCW = acc_width(DW, CW, NH);

  localparam logic signed [ACCW-1:0] HALF = ACCW'(1) << (SHIFT - 1);
  localparam logic signed [ACCW-1:0] YMAX = {{(ACCW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [ACCW-1:0] YMIN = ~YMAX;

  state_t                 state, state_nxt;
  logic [PW-1:0]          ph;
  logic [KW-1:0]          k;
  logic [IW-1:0]          k_mir;
  logic [DW-1:0]          line [NTAP];
  logic [DW-1:0]          snap [NTAP];
  logic [CW-1:0]          coef [NH];
  logic                   op_bypass;
  logic                   trig, accept, drop, mac_en, mac_last;
  logic [ACCW-1:0]        acc;
  logic signed [ACCW-1:0] rnd, shf;
  logic [DW-1:0]          y;
  logic                   y_sat;

  assign trig  = clk_vld_in && (ph == PW'(DEC - 1));
  assign k_mir = IW'(NTAP - 1) - IW'(k);

  // Input side: phase counter and delay line run regardless of FSM state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph <= '0;
      for (int unsigned j = 0; j < NTAP; j++) line[j] <= '0;
    end else if (clk_vld_in) begin
      ph      <= (ph == PW'(DEC - 1)) ? '0 : ph + 1'b1;
      line[0] <= dat_in;
      for (int unsigned j = 1; j < NTAP; j++) line[j] <= line[j-1];
    end
  end

  // Snapshot is the post-shift line, so the new sample lands in s[0].
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_bypass <= 1'b0;
      for (int unsigned j = 0; j < NTAP; j++) snap[j] <= '0;
    end else if (accept) begin
      op_bypass <= bypass;
      snap[0]   <= dat_in;
      for (int unsigned j = 1; j < NTAP; j++) snap[j] <= line[j-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned j = 0; j < NH; j++) coef[j] <= '0;
    end else if (coef_we && !busy && (int'(coef_addr) < NH)) begin
      coef[coef_addr] <= coef_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         k <= '0;
    else if (accept) k <= '0;
    else if (mac_en) k <= k + 1'b1;
  end

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (trig) state_nxt = bypass ? OUT : MAC;
      MAC:     if (mac_last) state_nxt = OUT;
      OUT:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state != IDLE);
    mac_en   = (state == MAC);
    mac_last = (k == KW'(NH - 1));
    accept   = trig && (state == IDLE);
    drop     = trig && (state != IDLE);
  end

  cic_comp_mac #(
    .DW   (DW),
    .CW   (CW),
    .ACCW (ACCW)
  ) u_mac (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (mac_en),
    .single (mac_last),
    .x0     (snap[k]),
    .x1     (snap[k_mir]),
    .coef   (coef[k]),
    .acc    (acc)
  );

  // Round half up, arithmetic shift, then clamp to the DW-bit range.
  always_comb begin
    rnd   = $signed(acc) + HALF;
    shf   = rnd >>> SHIFT;
    y_sat = 1'b1;
    if (shf > YMAX)      y = {1'b0, {(DW-1){1'b1}}};
    else if (shf < YMIN) y = {1'b1, {(DW-1){1'b0}}};
    else begin
      y     = shf[DW-1:0];
      y_sat = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_vld_out <= 1'b0;
      dat_out     <= '0;
      sat         <= 1'b0;
    end else begin
      clk_vld_out <= (state == OUT);
      if (state == OUT) begin
        if (op_bypass) begin
          dat_out <= snap[0];
        end else begin
          dat_out <= y;
          if (y_sat) sat <= 1'b1;
        end
      end
    end
  end

  // A drop in the same cycle as ovr_clr leaves the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          overrun <= 1'b0;
    else if (drop)    overrun <= 1'b1;
    else if (ovr_clr) overrun <= 1'b0;
  end

endmodule
